// File: rtl/ahfp_add_arbiter.sv
// Round-robin arbiter sharing one ahfp_add adder among NREQ requesters, with a tag pipeline for result return.
// Define AHFP_ARB_FIXED_PRIO_EN to build a fixed-priority variant where the lowest valid index always wins.
module ahfp_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_dataa,
  input  logic [32*NREQ-1:0] req_datab,
  output logic [NREQ-1:0]    req_ready,
  output logic [31:0]        add_dataa,
  output logic [31:0]        add_datab,
  input  logic [31:0]        add_result,
  output logic [NREQ-1:0]    resp_valid,
  output logic [31:0]        resp_result,
  output logic               busy
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NST = LATENCY + 1;

  logic [31:0]     dataa_arr [NREQ];
  logic [31:0]     datab_arr [NREQ];
  logic            grant_any;
  logic [IW-1:0]   grant_idx;
  logic [NREQ-1:0] grant;

  logic [31:0]     add_dataa_q, add_dataa_d;
  logic [31:0]     add_datab_q, add_datab_d;
  logic [NST-1:0]  tag_vld_q, tag_vld_d;
  logic [IW-1:0]   tag_idx_q [NST];
  logic [IW-1:0]   tag_idx_d [NST];
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]     resp_result_q, resp_result_d;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign dataa_arr[gi] = req_dataa[32*gi +: 32];
      assign datab_arr[gi] = req_datab[32*gi +: 32];
    end
  endgenerate

`ifdef AHFP_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the one left standing.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = IW'(i);
      end
    end
    if (reset) grant_any = 1'b0;
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;

  // Scan offsets from far to near so the first valid index at or after ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req_valid[(int'(ptr_q) + off) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = IW'((int'(ptr_q) + off) % NREQ);
      end
    end
    if (reset) grant_any = 1'b0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    grant = '0;
    if (grant_any) grant = NREQ'(1) << grant_idx;
  end

  always_comb begin
    add_dataa_d = add_dataa_q;
    add_datab_d = add_datab_q;
    if (grant_any) begin
      add_dataa_d = dataa_arr[grant_idx];
      add_datab_d = datab_arr[grant_idx];
    end
  end

  // Tag pipeline never stalls; stage NST-1 lines up with add_result for its operation.
  always_comb begin
    tag_vld_d[0] = grant_any;
    tag_idx_d[0] = grant_idx;
    for (int s = 1; s < NST; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  always_comb begin
    resp_valid_d  = '0;
    resp_result_d = resp_result_q;
    if (tag_vld_q[NST-1]) begin
      resp_valid_d  = NREQ'(1) << tag_idx_q[NST-1];
      resp_result_d = add_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      add_dataa_q   <= '0;
      add_datab_q   <= '0;
      tag_vld_q     <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      for (int s = 0; s < NST; s++) tag_idx_q[s] <= '0;
    end else begin
      add_dataa_q   <= add_dataa_d;
      add_datab_q   <= add_datab_d;
      tag_vld_q     <= tag_vld_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      for (int s = 0; s < NST; s++) tag_idx_q[s] <= tag_idx_d[s];
    end
  end

  assign req_ready   = grant;
  assign add_dataa   = add_dataa_q;
  assign add_datab   = add_datab_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign busy        = |tag_vld_q;

endmodule

// File: tb/tb_ahfp_add_arbiter.sv
// Directed bench for ahfp_add_arbiter: one instance with LATENCY=0 and one with LATENCY=3 share the stimulus.
// Expected grants follow the fixed-priority rules when AHFP_ARB_FIXED_PRIO_EN is defined.
module tb_ahfp_add_arbiter;

`ifdef AHFP_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_dataa, req_datab;

  logic [3:0]   ready0, resp_valid0, ready3, resp_valid3;
  logic [31:0]  add_dataa0, add_datab0, add_result0, resp_result0;
  logic [31:0]  add_dataa3, add_datab3, add_result3, resp_result3;
  logic         busy0, busy3;
  logic [31:0]  pipe3 [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Adder stand-in: exact for the directed float vector, integer sum otherwise (only routing matters).
  function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + b;
  endfunction

  assign add_result0 = fake_add(add_dataa0, add_datab0);

  always @(posedge clk) begin
    pipe3[0] <= fake_add(add_dataa3, add_datab3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign add_result3 = pipe3[2];

  ahfp_add_arbiter #(.NREQ(4), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_dataa(req_dataa), .req_datab(req_datab),
    .req_ready(ready0), .add_dataa(add_dataa0), .add_datab(add_datab0), .add_result(add_result0),
    .resp_valid(resp_valid0), .resp_result(resp_result0), .busy(busy0)
  );

  ahfp_add_arbiter #(.NREQ(4), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_dataa(req_dataa), .req_datab(req_datab),
    .req_ready(ready3), .add_dataa(add_dataa3), .add_datab(add_datab3), .add_result(add_result3),
    .resp_valid(resp_valid3), .resp_result(resp_result3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] r;
    r = 4'b0001 << i;
    return r;
  endfunction

  initial begin
    int g;
    reset     = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_dataa[32*i +: 32] = 32'(i + 1);
      req_datab[32*i +: 32] = 32'((i + 1) << 8);
    end

    // Reset held two cycles with everyone requesting
    step();
    #1 check("rst_ready_during", {28'd0, ready3}, 32'h0);
    step();
    check("rst_ready0", {28'd0, ready0}, 32'h0);
    check("rst_resp_valid3", {28'd0, resp_valid3}, 32'h0);
    check("rst_busy3", {31'd0, busy3}, 32'h0);
    check("rst_busy0", {31'd0, busy0}, 32'h0);
    check("rst_add_dataa3", add_dataa3, 32'h0);
    check("rst_resp_result3", resp_result3, 32'h0);
    reset = 1'b0;

    // Full contention for 8 cycles, then drain
    for (int e = 0; e < 14; e++) begin
      req_valid = (e < 8) ? 4'hF : 4'h0;
      #1;
      check($sformatf("cont_ready_%0d", e), {28'd0, ready3},
            (e < 8) ? {28'd0, oh(FIXED ? 0 : e % 4)} : 32'h0);
      step();
      if (e == 0) check("cont_busy3", {31'd0, busy3}, 32'h1);
      g = e - 4;
      if (g >= 0 && g < 8) begin
        check($sformatf("cont_resp3_v_%0d", e), {28'd0, resp_valid3}, {28'd0, oh(FIXED ? 0 : g % 4)});
        check($sformatf("cont_resp3_r_%0d", e), resp_result3, 32'((FIXED ? 1 : g % 4 + 1) * 32'h101));
      end else begin
        check($sformatf("cont_resp3_v_%0d", e), {28'd0, resp_valid3}, 32'h0);
      end
      g = e - 1;
      check($sformatf("cont_resp0_v_%0d", e), {28'd0, resp_valid0},
            (g >= 0 && g < 8) ? {28'd0, oh(FIXED ? 0 : g % 4)} : 32'h0);
    end
    check("cont_busy3_idle", {31'd0, busy3}, 32'h0);

    // Single request from requester 2, LATENCY=0
    req_dataa[64 +: 32] = 32'h3F80_0000;
    req_datab[64 +: 32] = 32'h4000_0000;
    req_valid = 4'b0100;
    #1 check("single_ready", {28'd0, ready0}, 32'h4);
    step();
    req_valid = 4'h0;
    check("single_add_a", add_dataa0, 32'h3F80_0000);
    check("single_add_b", add_datab0, 32'h4000_0000);
    check("single_resp_early", {28'd0, resp_valid0}, 32'h0);
    step();
    check("single_resp_v", {28'd0, resp_valid0}, 32'h4);
    check("single_resp_r", resp_result0, 32'h4040_0000);
    step();
    check("single_resp_once", {28'd0, resp_valid0}, 32'h0);
    check("single_resp_hold", resp_result0, 32'h4040_0000);

    // Wrap-around from ptr=3 with requesters 1 and 3
    req_valid = 4'b1010;
    #1 check("wrap_first", {28'd0, ready0}, FIXED ? 32'h2 : 32'h8);
    step();
    check("wrap_second", {28'd0, ready0}, 32'h2);
    step();
    check("wrap_resp0", {28'd0, resp_valid0}, FIXED ? 32'h2 : 32'h8);
    req_valid = 4'b0011;
    #1 check("wrap_ptr2_a", {28'd0, ready0}, 32'h1);
    req_valid = 4'b1111;
    #1 check("wrap_ptr2_b", {28'd0, ready0}, FIXED ? 32'h1 : 32'h4);
    req_valid = 4'h0;
    repeat (6) step();

    // Three operations in flight, then a one-cycle reset
    for (int j = 0; j < 3; j++) begin
      req_valid = 4'hF;
      #1;
      if (j == 0) check("mid_ptr_held", {28'd0, ready3}, FIXED ? 32'h1 : 32'h4);
      step();
    end
    reset = 1'b1;
    #1 check("mid_rst_ready", {28'd0, ready3}, 32'h0);
    step();
    reset     = 1'b0;
    req_valid = 4'h0;
    check("mid_busy3", {31'd0, busy3}, 32'h0);
    check("mid_add_dataa3", add_dataa3, 32'h0);
    for (int j = 0; j < 5; j++) begin
      step();
      check($sformatf("mid_noresp3_%0d", j), {28'd0, resp_valid3}, 32'h0);
      check($sformatf("mid_noresp0_%0d", j), {28'd0, resp_valid0}, 32'h0);
    end
    req_valid = 4'hF;
    #1 check("mid_first_grant", {28'd0, ready3}, 32'h1);
    req_valid = 4'h0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
